// File: rtl/systolic_feeder.sv
// Operand feeder for the systolic array: buffers one A/B operand set, then streams
// it out with per-lane skew (row i delayed i cycles, column j delayed j cycles).
module systolic_feeder #(
    parameter int unsigned ROWS    = 2,
    parameter int unsigned COLUMNS = 2,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [ROWS*WIDTH-1:0]    load_a,
    input  logic [COLUMNS*WIDTH-1:0] load_b,
    output logic [ROWS*WIDTH-1:0]    a,
    output logic [COLUMNS*WIDTH-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     done
);

    localparam int unsigned L  = DEPTH + ROWS + COLUMNS - 2;
    localparam int unsigned KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (L > 1) ? $clog2(L) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(L - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                   state;
    logic [KW-1:0]            k;
    logic [TW-1:0]            t;
    int unsigned              t_ext;
    logic [ROWS*WIDTH-1:0]    abuf [DEPTH];
    logic [COLUMNS*WIDTH-1:0] bbuf [DEPTH];

    assign t_ext = 32'(t);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_LOAD;
            k          <= '0;
            t          <= '0;
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_valid && load_ready) begin
                        if (k == K_LAST) begin
                            k          <= '0;
                            t          <= '0;
                            state      <= S_STREAM;
                            load_ready <= 1'b0;
                            out_valid  <= 1'b1;
                            out_last   <= (L == 1);
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (t == T_LAST) begin
                            t         <= '0;
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            t        <= t + TW'(1);
                            out_last <= ((t + TW'(1)) == T_LAST);
                        end
                    end
                end
                S_DONE: begin
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                    state      <= S_LOAD;
                end
                default: begin
                    state      <= S_LOAD;
                    load_ready <= 1'b1;
                    out_valid  <= 1'b0;
                    out_last   <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    // Buffers carry no reset: every entry is rewritten by a full set before it is streamed.
    always_ff @(posedge clock) begin
        if (!reset && state == S_LOAD && load_valid) begin
            abuf[k] <= load_a;
            bbuf[k] <= load_b;
        end
    end

    // Lanes gather from registered state only, so out_ready/load_valid never reach a or b.
    always_comb begin
        a = '0;
        b = '0;
        if (state == S_STREAM) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                if (t_ext >= i && (t_ext - i) < DEPTH)
                    a[i*WIDTH +: WIDTH] = abuf[KW'(t_ext - i)][i*WIDTH +: WIDTH];
            end
            for (int unsigned j = 0; j < COLUMNS; j++) begin
                if (t_ext >= j && (t_ext - j) < DEPTH)
                    b[j*WIDTH +: WIDTH] = bbuf[KW'(t_ext - j)][j*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for the systolic multiply array. It buffers one A operand set (DEPTH columns of ROWS elements) and one B operand set (DEPTH rows of COLUMNS elements), then streams them into the array's `a`/`b` inputs. Row lane i and column lane j are skewed by i and j cycles respectively, and lanes outside their active window are zero-filled. It is the transmit side of the array's operand interface and supports output backpressure.

## Interface
- ROWS, 2, number of A lanes (array rows)
- COLUMNS, 2, number of B lanes (array columns)
- WIDTH, 8, element width in bits
- DEPTH, 4, inner dimension K: load beats per operand set, ≥1
- clock  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high; clears the FSM, counters and outputs
- load_valid  input  1  load beat offered
- load_ready  output  1  high in LOAD state only
- load_a  input  ROWS*WIDTH  beat k: A column k; lane i = bits [(i+1)*WIDTH-1 -: WIDTH]
- load_b  input  COLUMNS*WIDTH  beat k: B row k; lane j packed the same way
- a  output  ROWS*WIDTH  skewed A lanes to the array
- b  output  COLUMNS*WIDTH  skewed B lanes to the array
- out_valid  output  1  a/b carry a stream beat
- out_ready  input  1  consumer accepts the beat
- out_last  output  1  marks the final stream beat (t = L-1)
- done  output  1  one-cycle pulse after the final beat is accepted

## Operation
- Stream length L = DEPTH + ROWS + COLUMNS - 2. Counters are sized by $clog2 of their ranges (minimum 1 bit).
- FSM states are LOAD, STREAM and DONE. Reset puts the FSM in LOAD with load count k=0 and stream counter t=0.
- LOAD:
  - load_ready=1. A beat is accepted when load_valid && load_ready.
  - On acceptance, load_a is stored to abuf[k] and load_b to bbuf[k], and k increments.
  - When beat DEPTH-1 is accepted, the FSM moves to STREAM with t=0 and k=0.
- STREAM:
  - out_valid=1.
  - A lane i = abuf[t-i] lane i if 0 ≤ t-i < DEPTH, else 0.
  - B lane j = bbuf[t-j] lane j if 0 ≤ t-j < DEPTH, else 0.
  - out_last = (t == L-1).
  - t advances only on out_valid && out_ready. When the accepted beat is t=L-1, the FSM moves to DONE.
- DONE: lasts exactly 1 cycle with done=1, out_valid=0, load_ready=0, then the FSM returns to LOAD.
- Outputs are a pure function of registered state (FSM, t, buffers). There is no combinational path from out_ready or load_valid to any output.
- Outside STREAM, a and b are driven to 0.
- Buffers are not cleared by reset or by DONE. They are fully overwritten by each operand set before use.
- The buffers can be reused for a new load only after DONE. There is no overlap of loading and streaming.

## Timing
- Reset values: load_ready=1, out_valid=0, out_last=0, done=0, a=0, b=0.
- Reset takes priority over every other event on the same edge. Reset asserted mid-LOAD or mid-STREAM discards the partial set and the remaining stream. The cycle after reset shows the reset values.
- Load-to-stream latency: the cycle after the edge that accepts beat DEPTH-1 shows out_valid=1 with t=0.
- Throughput: with out_ready held high, a stream takes L consecutive cycles, then 1 DONE cycle, then load_ready=1.
- Backpressure: while out_ready=0, a, b, out_valid and out_last hold stable. out_ready may toggle on any cycle.
- load_valid during STREAM or DONE is ignored, and no beat is stored.
- Each operand set needs DEPTH accepted beats. Gaps in load_valid simply stall the load count.

## Test plan
- Basic stream (ROWS=COLUMNS=DEPTH=2, WIDTH=8): load beats (load_a=16'h0301, load_b=16'h0605), then (16'h0402, 16'h0807). With out_ready=1, the stream must be exactly:
  - a: 16'h0001, 16'h0302, 16'h0400, 16'h0000
  - b: 16'h0005, 16'h0607, 16'h0800, 16'h0000
  - out_last on the 4th beat, done on the next cycle, then load_ready=1.
- Backpressure: same data, out_ready=0 for 3 cycles at t=1. a must hold 16'h0302 and b must hold 16'h0607 throughout. The beat count stays 4 and done is delayed by 3 cycles.
- Load gaps: load_valid pulsed every other cycle. The stream must start exactly 1 cycle after the 2nd accepted beat, and the data must match the basic stream.
- Ignored loads: assert load_valid with 16'hFFFF data throughout STREAM and DONE. The stream must be unchanged, and the next set must load normally.
- Reset mid-stream: assert reset at t=2 for 1 cycle. Next cycle: out_valid=0, done=0, a=b=0, load_ready=1. A fresh 2-beat load must then stream correctly.
- Asymmetric shape (ROWS=3, COLUMNS=2, DEPTH=3): L=6. Check the skew: a lane 2 is nonzero only at t=2..4, and b lane 1 only at t=1..3.
